// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared tank game codes, playfield defaults and bullet engine states
package tank_pkg;

  typedef enum logic [2:0] {
    LEFT  = 3'd0,
    RIGHT = 3'd1,
    UP    = 3'd2,
    DOWN  = 3'd3,
    STOP  = 3'd4
  } dir_e;

  localparam logic OWNER_PLAYER = 1'b0;
  localparam logic OWNER_ENEMY  = 1'b1;

  localparam int FIELD_W_DEF     = 550;
  localparam int FIELD_H_DEF     = 450;
  localparam int TARGET_SIZE_DEF = 30;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/bullet_pool_engine_if.sv
// rtl/bullet_pool_engine_if.sv - spawn, target, hit and renderer-read signals of the bullet pool
interface bullet_pool_engine_if #(
  parameter int N_BULLETS = 16,
  parameter int X_W       = 10,
  parameter int Y_W       = 10,
  parameter int N_TARGETS = 4
);
  localparam int IDX_W = $clog2(N_BULLETS);
  localparam int TGT_W = $clog2(N_TARGETS);

  logic                     spawn_valid;
  logic                     spawn_ready;
  logic [X_W-1:0]           spawn_x;
  logic [Y_W-1:0]           spawn_y;
  logic [2:0]               spawn_dir;
  logic                     spawn_owner;
  logic [N_TARGETS*X_W-1:0] target_x;
  logic [N_TARGETS*Y_W-1:0] target_y;
  logic [N_TARGETS-1:0]     target_alive;
  logic                     hit_valid;
  logic [TGT_W-1:0]         hit_target;
  logic                     hit_owner;
  logic [IDX_W-1:0]         rd_idx;
  logic                     rd_valid;
  logic [X_W-1:0]           rd_x;
  logic [Y_W-1:0]           rd_y;

  modport master (
    output spawn_valid, spawn_x, spawn_y, spawn_dir, spawn_owner,
    output target_x, target_y, target_alive, rd_idx,
    input  spawn_ready, hit_valid, hit_target, hit_owner, rd_valid, rd_x, rd_y
  );

  modport slave (
    input  spawn_valid, spawn_x, spawn_y, spawn_dir, spawn_owner,
    input  target_x, target_y, target_alive, rd_idx,
    output spawn_ready, hit_valid, hit_target, hit_owner, rd_valid, rd_x, rd_y
  );
endinterface

// File: rtl/bullet_pool_engine_hit_detect.sv
// rtl/bullet_pool_engine_hit_detect.sv - next position, edge flag and lowest target match for one slot
// BULLET_WRAP_EN: wrap across field edges instead of flagging out-of-range.
module bullet_hit_detect
  import tank_pkg::*;
#(
  parameter int X_W         = 10,
  parameter int Y_W         = 10,
  parameter int FIELD_W     = FIELD_W_DEF,
  parameter int FIELD_H     = FIELD_H_DEF,
  parameter int STEP        = 2,
  parameter int N_TARGETS   = 4,
  parameter int TARGET_SIZE = TARGET_SIZE_DEF,
  parameter int TGT_W       = $clog2(N_TARGETS)
) (
  input  logic [X_W-1:0]           x,
  input  logic [Y_W-1:0]           y,
  input  dir_e                     dir,
  input  logic                     owner,
  input  logic [N_TARGETS*X_W-1:0] target_x,
  input  logic [N_TARGETS*Y_W-1:0] target_y,
  input  logic [N_TARGETS-1:0]     target_alive,
  output logic [X_W-1:0]           nx,
  output logic [Y_W-1:0]           ny,
  output logic                     out_of_range,
  output logic                     hit,
  output logic [TGT_W-1:0]         hit_idx
);
  localparam logic [X_W:0] STEP_X = (X_W+1)'(STEP);
  localparam logic [Y_W:0] STEP_Y = (Y_W+1)'(STEP);
  localparam logic [X_W:0] FW     = (X_W+1)'(FIELD_W);
  localparam logic [Y_W:0] FH     = (Y_W+1)'(FIELD_H);
  localparam logic [X_W:0] FW_M1  = (X_W+1)'(FIELD_W - 1);
  localparam logic [Y_W:0] FH_M1  = (Y_W+1)'(FIELD_H - 1);
  localparam logic [X_W:0] TS_X   = (X_W+1)'(TARGET_SIZE - 1);
  localparam logic [Y_W:0] TS_Y   = (Y_W+1)'(TARGET_SIZE - 1);

  logic [X_W:0] xe, nxe;
  logic [Y_W:0] ye, nye;
  logic         edge_cross;

  // One extra bit on every coordinate so edge tests never wrap.
  always_comb begin
    xe         = {1'b0, x};
    ye         = {1'b0, y};
    nxe        = xe;
    nye        = ye;
    edge_cross = 1'b0;
    case (dir)
      LEFT: begin
        edge_cross = xe < STEP_X;
        nxe        = edge_cross ? xe + FW - STEP_X : xe - STEP_X;
      end
      RIGHT: begin
        edge_cross = xe + STEP_X > FW_M1;
        nxe        = edge_cross ? xe + STEP_X - FW : xe + STEP_X;
      end
      UP: begin
        edge_cross = ye < STEP_Y;
        nye        = edge_cross ? ye + FH - STEP_Y : ye - STEP_Y;
      end
      DOWN: begin
        edge_cross = ye + STEP_Y > FH_M1;
        nye        = edge_cross ? ye + STEP_Y - FH : ye + STEP_Y;
      end
      default: edge_cross = 1'b0;
    endcase
  end

  assign nx = nxe[X_W-1:0];
  assign ny = nye[Y_W-1:0];

`ifdef BULLET_WRAP_EN
  assign out_of_range = 1'b0;
`else
  assign out_of_range = edge_cross;
`endif

  // Player bullets only hurt enemies (1..N-1); enemy bullets only hurt the player (0).
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_TARGETS - 1; i >= 0; i--) begin
      if (target_alive[i] &&
          ((owner == OWNER_PLAYER) ? (i != 0) : (i == 0)) &&
          nxe >= {1'b0, target_x[i*X_W +: X_W]} &&
          nxe <= {1'b0, target_x[i*X_W +: X_W]} + TS_X &&
          nye >= {1'b0, target_y[i*Y_W +: Y_W]} &&
          nye <= {1'b0, target_y[i*Y_W +: Y_W]} + TS_Y) begin
        hit     = 1'b1;
        hit_idx = TGT_W'(i);
      end
    end
  end
endmodule

// File: rtl/bullet_pool_engine.sv
// rtl/bullet_pool_engine.sv - fixed pool of bullet slots with spawn handshake and per-tick sweep
// BULLET_WRAP_EN: bullets wrap at field edges instead of being retired.
module bullet_pool_engine
  import tank_pkg::*;
#(
  parameter int N_BULLETS   = 16,
  parameter int X_W         = 10,
  parameter int Y_W         = 10,
  parameter int FIELD_W     = FIELD_W_DEF,
  parameter int FIELD_H     = FIELD_H_DEF,
  parameter int STEP        = 2,
  parameter int N_TARGETS   = 4,
  parameter int TARGET_SIZE = TARGET_SIZE_DEF
) (
  input  logic                             clk,
  input  logic                             RSTN,
  input  logic                             tick,
  bullet_pool_engine_if.slave              bus,
  output logic [$clog2(N_BULLETS+1)-1:0]   active_count,
  output logic                             busy,
  output logic                             tick_overrun
);
  localparam int IDX_W = $clog2(N_BULLETS);
  localparam int TGT_W = $clog2(N_TARGETS);
  localparam int CNT_W = $clog2(N_BULLETS + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_BULLETS - 1);

  sweep_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             pending_q, pending_d, overrun_d;

  logic [N_BULLETS-1:0] slot_valid;
  logic [N_BULLETS-1:0] slot_owner;
  logic [X_W-1:0]       slot_x   [N_BULLETS];
  logic [Y_W-1:0]       slot_y   [N_BULLETS];
  dir_e                 slot_dir [N_BULLETS];

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [X_W-1:0]   nx;
  logic [Y_W-1:0]   ny;
  logic             oor, hit;
  logic [TGT_W-1:0] hit_idx;
  logic             sweep_live, do_retire, do_move, do_hit, do_alloc;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = N_BULLETS - 1; i >= 0; i--) begin
      if (!slot_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign bus.spawn_ready = (state_q == IDLE) && free_found;
  assign busy            = (state_q == SWEEP);

  bullet_hit_detect #(
    .X_W(X_W), .Y_W(Y_W), .FIELD_W(FIELD_W), .FIELD_H(FIELD_H), .STEP(STEP),
    .N_TARGETS(N_TARGETS), .TARGET_SIZE(TARGET_SIZE), .TGT_W(TGT_W)
  ) u_hit_detect (
    .x(slot_x[idx_q]), .y(slot_y[idx_q]), .dir(slot_dir[idx_q]), .owner(slot_owner[idx_q]),
    .target_x(bus.target_x), .target_y(bus.target_y), .target_alive(bus.target_alive),
    .nx(nx), .ny(ny), .out_of_range(oor), .hit(hit), .hit_idx(hit_idx)
  );

  // A tick landing in the final sweep cycle is held as pending and restarts from IDLE.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    overrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        pending_d = 1'b0;
        if (tick || pending_q) state_d = SWEEP;
      end
      SWEEP: begin
        if (idx_q == LAST) begin
          state_d   = pending_q ? SWEEP : IDLE;
          pending_d = 1'b0;
        end
        if (tick) begin
          if (pending_q) overrun_d = 1'b1;
          else           pending_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RSTN) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      tick_overrun <= overrun_d;
      idx_q        <= (state_q == SWEEP && idx_q != LAST) ? idx_q + IDX_W'(1) : '0;
    end
  end

  assign sweep_live = (state_q == SWEEP) && slot_valid[idx_q];
  assign do_retire  = sweep_live && oor;
  assign do_move    = sweep_live && !oor;
  assign do_hit     = do_move && hit;
  assign do_alloc   = bus.spawn_valid && bus.spawn_ready && (bus.spawn_dir < STOP);

  always_ff @(posedge clk) begin
    if (RSTN) begin
      slot_valid     <= '0;
      active_count   <= '0;
      bus.hit_valid  <= 1'b0;
      bus.hit_target <= '0;
      bus.hit_owner  <= 1'b0;
      bus.rd_valid   <= 1'b0;
      bus.rd_x       <= '0;
      bus.rd_y       <= '0;
    end else begin
      bus.hit_valid <= do_hit;
      if (do_hit) begin
        bus.hit_target <= hit_idx;
        bus.hit_owner  <= slot_owner[idx_q];
      end
      if (do_alloc) begin
        slot_valid[free_idx] <= 1'b1;
        slot_x[free_idx]     <= bus.spawn_x;
        slot_y[free_idx]     <= bus.spawn_y;
        slot_dir[free_idx]   <= dir_e'(bus.spawn_dir);
        slot_owner[free_idx] <= bus.spawn_owner;
        active_count         <= active_count + CNT_W'(1);
      end
      if (do_move) begin
        slot_x[idx_q] <= nx;
        slot_y[idx_q] <= ny;
      end
      if (do_retire || do_hit) begin
        slot_valid[idx_q] <= 1'b0;
        active_count      <= active_count - CNT_W'(1);
      end
      bus.rd_valid <= slot_valid[bus.rd_idx];
      bus.rd_x     <= slot_x[bus.rd_idx];
      bus.rd_y     <= slot_y[bus.rd_idx];
    end
  end
endmodule

// File: tb/tb_bullet_pool_engine.sv
// tb/tb_bullet_pool_engine.sv - self-checking bench for bullet_pool_engine
module tb_bullet_pool_engine;
  import tank_pkg::*;

  localparam int NB = 16;
  localparam int XW = 10;
  localparam int YW = 10;
  localparam int NT = 4;

  logic       clk = 1'b0;
  logic       RSTN;
  logic       tick;
  logic [4:0] active_count;
  logic       busy;
  logic       tick_overrun;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] tgt;
    logic       owner;
  } hit_t;

  hit_t exp_q[$];
  hit_t got_q[$];

  bullet_pool_engine_if #(.N_BULLETS(NB), .X_W(XW), .Y_W(YW), .N_TARGETS(NT)) bus ();

  bullet_pool_engine #(.N_BULLETS(NB), .X_W(XW), .Y_W(YW), .N_TARGETS(NT)) dut (
    .clk(clk), .RSTN(RSTN), .tick(tick), .bus(bus),
    .active_count(active_count), .busy(busy), .tick_overrun(tick_overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.hit_valid === 1'b1) got_q.push_back({bus.hit_target, bus.hit_owner});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_target(input int i, input int x, input int y, input bit alive);
    bus.target_x[i*XW +: XW] = XW'(x);
    bus.target_y[i*YW +: YW] = YW'(y);
    bus.target_alive[i]      = alive;
  endtask

  task automatic do_reset();
    RSTN = 1'b1; tick = 1'b0; bus.spawn_valid = 1'b0; bus.rd_idx = '0;
    bus.spawn_x = '0; bus.spawn_y = '0; bus.spawn_dir = '0; bus.spawn_owner = 1'b0;
    bus.target_x = '0; bus.target_y = '0; bus.target_alive = '0;
    step(); step();
    RSTN = 1'b0;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic spawn(input int x, input int y, input logic [2:0] dir, input logic owner,
                       output bit accepted);
    bus.spawn_x = XW'(x); bus.spawn_y = YW'(y); bus.spawn_dir = dir; bus.spawn_owner = owner;
    bus.spawn_valid = 1'b1;
    accepted = bus.spawn_ready;
    step();
    bus.spawn_valid = 1'b0;
  endtask

  task automatic run_tick();
    int cycles;
    tick = 1'b1;
    step();
    tick = 1'b0;
    cycles = 0;
    while (busy && cycles < 200) begin
      step();
      cycles++;
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL sweep_timeout busy=%0d after %0d cycles", busy, cycles); end
    step();
  endtask

  task automatic read_slot(input int idx, output logic v, output int x, output int y);
    bus.rd_idx = 4'(idx);
    step();
    v = bus.rd_valid; x = int'(bus.rd_x); y = int'(bus.rd_y);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.spawn_ready !== 1'b1) begin failures++; $display("FAIL reset_spawn_ready got=%0d exp=1", bus.spawn_ready); end
    checks++; if (active_count !== 5'd0) begin failures++; $display("FAIL reset_active_count got=%0d exp=0", active_count); end
    checks++; if (bus.hit_valid !== 1'b0) begin failures++; $display("FAIL reset_hit_valid got=%0d exp=0", bus.hit_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", busy); end
    checks++; if (tick_overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0d exp=0", tick_overrun); end
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%0d exp=0", bus.rd_valid); end
  endtask

  task automatic test_spawn_move();
    bit acc; logic v; int x, y;
    do_reset();
    spawn(100, 100, STOP, OWNER_PLAYER, acc);
    checks++; if (acc !== 1'b1) begin failures++; $display("FAIL stop_handshake got=%0d exp=1", acc); end
    checks++; if (active_count !== 5'd0) begin failures++; $display("FAIL stop_no_alloc got=%0d exp=0", active_count); end
    spawn(100, 100, RIGHT, OWNER_PLAYER, acc);
    checks++; if (active_count !== 5'd1) begin failures++; $display("FAIL spawn_count got=%0d exp=1", active_count); end
    run_tick();
    read_slot(0, v, x, y);
    checks++; if ({v, 10'(x), 10'(y)} !== {1'b1, 10'd102, 10'd100}) begin failures++; $display("FAIL move_right got=%0d,%0d,%0d exp=1,102,100", v, x, y); end
    checks++; if (active_count !== 5'd1) begin failures++; $display("FAIL move_count got=%0d exp=1", active_count); end
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL move_no_hit got=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_fill_reuse();
    bit acc; logic v; int x, y; int acc_cnt;
    do_reset();
    acc_cnt = 0;
    for (int i = 0; i < NB; i++) begin
      spawn((i == 5) ? 548 : 100 + i * 10, 50 + i * 5, RIGHT, OWNER_PLAYER, acc);
      if (acc) acc_cnt++;
    end
    checks++; if (acc_cnt !== NB) begin failures++; $display("FAIL fill_accepts got=%0d exp=%0d", acc_cnt, NB); end
    checks++; if (bus.spawn_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0d exp=0", bus.spawn_ready); end
    spawn(20, 20, UP, OWNER_PLAYER, acc);
    checks++; if ({acc, active_count} !== {1'b0, 5'd16}) begin failures++; $display("FAIL full_reject got=%0d/%0d exp=0/16", acc, active_count); end
    run_tick();
    checks++; if ({bus.spawn_ready, active_count} !== {1'b1, 5'd15}) begin failures++; $display("FAIL retire_edge got=%0d/%0d exp=1/15", bus.spawn_ready, active_count); end
    read_slot(5, v, x, y);
    checks++; if (v !== 1'b0) begin failures++; $display("FAIL retired_slot got=%0d exp=0", v); end
    spawn(10, 10, DOWN, OWNER_ENEMY, acc);
    read_slot(5, v, x, y);
    checks++; if ({v, 10'(x), 10'(y)} !== {1'b1, 10'd10, 10'd10}) begin failures++; $display("FAIL reuse_slot got=%0d,%0d,%0d exp=1,10,10", v, x, y); end
    read_slot(6, v, x, y);
    checks++; if ({v, 10'(x), 10'(y)} !== {1'b1, 10'd162, 10'd80}) begin failures++; $display("FAIL slot6_move got=%0d,%0d,%0d exp=1,162,80", v, x, y); end
    checks++; if (active_count !== 5'd16) begin failures++; $display("FAIL refill_count got=%0d exp=16", active_count); end
  endtask

  task automatic test_hit();
    bit acc; hit_t g, e;
    do_reset();
    set_target(0, 500, 400, 1'b1);
    set_target(1, 30, 30, 1'b1);
    set_target(2, 100, 30, 1'b1);
    set_target(3, 40, 35, 1'b1);
    spawn(58, 40, LEFT, OWNER_PLAYER, acc);  exp_q.push_back({2'd1, OWNER_PLAYER});
    spawn(132, 40, LEFT, OWNER_PLAYER, acc);
    spawn(131, 40, LEFT, OWNER_PLAYER, acc); exp_q.push_back({2'd2, OWNER_PLAYER});
    spawn(58, 40, LEFT, OWNER_ENEMY, acc);
    run_tick();
    checks++; if (active_count !== 5'd2) begin failures++; $display("FAIL hit_count1 got=%0d exp=2", active_count); end
    set_target(0, 50, 30, 1'b1);
    exp_q.push_back({2'd2, OWNER_PLAYER});
    exp_q.push_back({2'd0, OWNER_ENEMY});
    run_tick();
    checks++; if (active_count !== 5'd0) begin failures++; $display("FAIL hit_count2 got=%0d exp=0", active_count); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL hit_events got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL hit_event got=tgt%0d/own%0d exp=tgt%0d/own%0d", g.tgt, g.owner, e.tgt, e.owner); end
    end
  endtask

  task automatic test_edge_retire();
    bit acc; logic v; int x, y;
    do_reset();
    spawn(1, 200, LEFT, OWNER_PLAYER, acc);
    spawn(547, 300, RIGHT, OWNER_PLAYER, acc);
    spawn(300, 1, UP, OWNER_ENEMY, acc);
    spawn(300, 448, DOWN, OWNER_ENEMY, acc);
    run_tick();
    read_slot(1, v, x, y);
    checks++; if ({v, 10'(x), 10'(y)} !== {1'b1, 10'd549, 10'd300}) begin failures++; $display("FAIL right_edge_keep got=%0d,%0d,%0d exp=1,549,300", v, x, y); end
`ifdef BULLET_WRAP_EN
    checks++; if (active_count !== 5'd4) begin failures++; $display("FAIL wrap_count got=%0d exp=4", active_count); end
    read_slot(0, v, x, y);
    checks++; if ({v, 10'(x), 10'(y)} !== {1'b1, 10'd549, 10'd200}) begin failures++; $display("FAIL wrap_left got=%0d,%0d,%0d exp=1,549,200", v, x, y); end
    read_slot(2, v, x, y);
    checks++; if ({v, 10'(x), 10'(y)} !== {1'b1, 10'd300, 10'd449}) begin failures++; $display("FAIL wrap_up got=%0d,%0d,%0d exp=1,300,449", v, x, y); end
    read_slot(3, v, x, y);
    checks++; if ({v, 10'(x), 10'(y)} !== {1'b1, 10'd300, 10'd0}) begin failures++; $display("FAIL wrap_down got=%0d,%0d,%0d exp=1,300,0", v, x, y); end
`else
    checks++; if (active_count !== 5'd1) begin failures++; $display("FAIL retire_count got=%0d exp=1", active_count); end
    read_slot(0, v, x, y);
    checks++; if (v !== 1'b0) begin failures++; $display("FAIL retire_left got=%0d exp=0", v); end
    read_slot(3, v, x, y);
    checks++; if (v !== 1'b0) begin failures++; $display("FAIL retire_down got=%0d exp=0", v); end
`endif
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL edge_no_hit got=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit acc; logic v; int x, y; int busy_cnt, ov_cnt, c;
    do_reset();
    spawn(100, 100, RIGHT, OWNER_PLAYER, acc);
    busy_cnt = 0; ov_cnt = 0; c = 0;
    while (c < 200) begin
      tick = (c == 0 || c == 3 || c == 6);
      step();
      if (busy) busy_cnt++;
      if (tick_overrun) ov_cnt++;
      if (c > 8 && !busy) break;
      c++;
    end
    tick = 1'b0;
    checks++; if (busy_cnt !== 2 * NB) begin failures++; $display("FAIL b2b_busy_cycles got=%0d exp=%0d", busy_cnt, 2 * NB); end
    checks++; if (ov_cnt !== 1) begin failures++; $display("FAIL b2b_overrun got=%0d exp=1", ov_cnt); end
    read_slot(0, v, x, y);
    checks++; if ({v, 10'(x)} !== {1'b1, 10'd104}) begin failures++; $display("FAIL b2b_two_moves got=%0d,%0d exp=1,104", v, x); end
    tick = 1'b1; step(); tick = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midsweep_busy got=%0d exp=1", busy); end
    RSTN = 1'b1; step(); RSTN = 1'b0;
    checks++; if ({busy, active_count, bus.hit_valid} !== {1'b0, 5'd0, 1'b0}) begin failures++; $display("FAIL midsweep_reset got=%0d/%0d/%0d exp=0/0/0", busy, active_count, bus.hit_valid); end
    read_slot(0, v, x, y);
    checks++; if ({v, busy} !== 2'b00) begin failures++; $display("FAIL midsweep_cleared got=%0d/%0d exp=0/0", v, busy); end
  endtask

  initial begin
    test_reset();
    test_spawn_move();
    test_fill_reuse();
    test_hit();
    test_edge_retire();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
